// File: rtl/cmac_tx_axis_arbiter.sv
// cmac_tx_axis_arbiter: packet-granular round-robin arbiter onto the CMAC TX AXI-Stream port
module cmac_tx_axis_arbiter #(
  parameter int NUM_SRC = 2,
  parameter int DATA_W = 512,
  parameter int TIMEOUT = 1024,
  localparam int KEEP_W = DATA_W / 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       link_up,
  input  logic [NUM_SRC-1:0]         s_axis_tvalid,
  output logic [NUM_SRC-1:0]         s_axis_tready,
  input  logic [NUM_SRC*DATA_W-1:0]  s_axis_tdata,
  input  logic [NUM_SRC*KEEP_W-1:0]  s_axis_tkeep,
  input  logic [NUM_SRC-1:0]         s_axis_tlast,
  input  logic [NUM_SRC-1:0]         s_axis_tuser,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [DATA_W-1:0]          m_axis_tdata,
  output logic [KEEP_W-1:0]          m_axis_tkeep,
  output logic                       m_axis_tlast,
  output logic                       m_axis_tuser,
  output logic [NUM_SRC-1:0]         grant,
  output logic                       busy,
  output logic [15:0]                abort_count
);
  localparam int IW = $clog2(NUM_SRC);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, XFER, ABORT, DRAIN} state_t;
  state_t state, state_nx;
  logic [IW-1:0] gidx, last_idx, pick;
  logic pick_ok, sel_valid;
  logic [CW-1:0] cnt;
  assign sel_valid = s_axis_tvalid[gidx];
  assign busy = state != IDLE;
  assign grant = busy ? NUM_SRC'(1) << gidx : '0;
  // round-robin pick: scan downward so the closest index after last_idx wins
  always_comb begin
    pick = '0;
    pick_ok = 1'b0;
    for (int k = NUM_SRC; k >= 1; k--)
      if (s_axis_tvalid[(int'(last_idx) + k) % NUM_SRC]) begin
        pick = IW'((int'(last_idx) + k) % NUM_SRC);
        pick_ok = 1'b1;
      end
  end
  // next state and datapath steering; the abort beat is a constant so it stays stable under backpressure
  always_comb begin
    state_nx = state;
    s_axis_tready = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata = '0;
    m_axis_tkeep = '0;
    m_axis_tlast = 1'b0;
    m_axis_tuser = 1'b0;
    case (state)
      IDLE: if (link_up && pick_ok) state_nx = XFER;
      XFER: begin
        m_axis_tvalid = sel_valid;
        m_axis_tdata = s_axis_tdata[gidx*DATA_W +: DATA_W];
        m_axis_tkeep = s_axis_tkeep[gidx*KEEP_W +: KEEP_W];
        m_axis_tlast = s_axis_tlast[gidx];
        m_axis_tuser = s_axis_tuser[gidx];
        s_axis_tready[gidx] = m_axis_tready;
        if (sel_valid && m_axis_tready && s_axis_tlast[gidx]) state_nx = IDLE;
        else if (!sel_valid && cnt + 1'b1 == CW'(TIMEOUT - 1)) state_nx = ABORT;
      end
      ABORT: begin
        m_axis_tvalid = 1'b1;
        m_axis_tkeep = '1;
        m_axis_tlast = 1'b1;
        m_axis_tuser = 1'b1;
        if (m_axis_tready) state_nx = DRAIN;
      end
      DRAIN: begin
        s_axis_tready[gidx] = 1'b1;
        if (sel_valid && s_axis_tlast[gidx]) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  // state, owner, stall counter and saturating abort counter
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      gidx <= '0;
      last_idx <= IW'(NUM_SRC - 1);
      cnt <= '0;
      abort_count <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE) gidx <= pick;
      cnt <= (state == XFER && !sel_valid) ? cnt + 1'b1 : '0;
      if (state != IDLE && state_nx == IDLE) last_idx <= gidx;
      if (state == ABORT && m_axis_tready && abort_count != 16'hFFFF) abort_count <= abort_count + 1'b1;
    end
endmodule

// File: tb/tb_cmac_tx_axis_arbiter.sv
// tb_cmac_tx_axis_arbiter: directed and randomized check of the CMAC TX arbiter against a packet-level model
module tb_cmac_tx_axis_arbiter;
  localparam int N = 3, DW = 32, KW = 4, TO = 16;
  logic clk = 1'b0, reset, link_up;
  logic [N-1:0] s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser, grant;
  logic [N*DW-1:0] s_axis_tdata;
  logic [N*KW-1:0] s_axis_tkeep;
  logic m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser, busy;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic [15:0] abort_count;
  always #5 clk = ~clk;
  cmac_tx_axis_arbiter #(.NUM_SRC(N), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .link_up(link_up),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .grant(grant), .busy(busy), .abort_count(abort_count)
  );
  int total = 0, passed = 0, fails = 0, cyc = 0;
  int sp[N], sb[N], lim[N], budget[N], mp[N], mb[N];
  int lens[N][64];
  int gap = 0, mrdy = 100, own = -1, last_own = N - 1;
  logic [N-1:0] vld, hs;
  logic m_hs, lnk = 1'b0;
  bit mon_on = 0;
  function automatic logic [DW-1:0] dat(int i, int p, int b);
    return {4'(i), 12'(p), 8'(b), 8'h5A};
  endfunction
  function automatic bit lst(int i, int p, int b);
    return b == lens[i][p] - 1;
  endfunction
  function automatic logic [KW-1:0] kp(int i, int p, int b);
    return lst(i, p, b) ? 4'b0011 : 4'b1111;
  endfunction
  function automatic bit usr(int p);
    return p % 3 == 2;
  endfunction
  function automatic int rr(int last, logic [N-1:0] v);
    for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic src_init(int fl);
    for (int i = 0; i < N; i++) begin
      sp[i] = 0; sb[i] = 0; lim[i] = 0; budget[i] = -1; mp[i] = 0; mb[i] = 0;
      for (int p = 0; p < 64; p++) lens[i][p] = fl != 0 ? fl : int'($urandom_range(4, 1));
    end
    vld = '0; hs = '0; m_hs = 1'b0; own = -1; last_own = N - 1; gap = 0; mrdy = 100;
    s_axis_tvalid = '0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = '0; s_axis_tuser = '0;
    m_axis_tready = 1'b0;
  endtask
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        if (budget[i] > 0) budget[i]--;
        if (lst(i, sp[i], sb[i])) begin sp[i]++; sb[i] = 0; end else sb[i]++;
      end
      if (!(vld[i] && !hs[i]))
        vld[i] = budget[i] != 0 && (sb[i] != 0 || sp[i] < lim[i]) && $urandom_range(99) >= gap;
      s_axis_tvalid[i] = vld[i];
      s_axis_tdata[i*DW +: DW] = dat(i, sp[i], sb[i]);
      s_axis_tkeep[i*KW +: KW] = kp(i, sp[i], sb[i]);
      s_axis_tlast[i] = lst(i, sp[i], sb[i]);
      s_axis_tuser[i] = usr(sp[i]);
    end
    m_axis_tready = $urandom_range(99) < mrdy;
    link_up = lnk;
  endtask
  task automatic monitor();
    logic [N-1:0] eg, et;
    eg = own < 0 ? '0 : N'(1) << own;
    et = own < 0 ? '0 : N'(m_axis_tready) << own;
    chk("grant", grant, eg);
    chk("s_tready", s_axis_tready, et);
    chk("m_tvalid", m_axis_tvalid, own < 0 ? 1'b0 : s_axis_tvalid[own]);
    if (own >= 0 && m_hs) begin
      chk("m_tdata", m_axis_tdata, dat(own, mp[own], mb[own]));
      chk("m_tkeep", m_axis_tkeep, kp(own, mp[own], mb[own]));
      chk("m_tlast", m_axis_tlast, lst(own, mp[own], mb[own]));
      chk("m_tuser", m_axis_tuser, usr(mp[own]));
      if (lst(own, mp[own], mb[own])) begin mp[own]++; mb[own] = 0; last_own = own; own = -1; end
      else mb[own]++;
    end else if (own < 0 && link_up && |s_axis_tvalid) own = rr(last_own, s_axis_tvalid);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    drive();
    cyc++;
    @(negedge clk);
    hs = s_axis_tvalid & s_axis_tready;
    m_hs = m_axis_tvalid & m_axis_tready;
    if (mon_on) monitor();
  endtask
  initial begin
    int hc[$];
    logic [N-1:0] hg[$];
    int bad, drops, seen;
    reset = 1'b1;
    link_up = 1'b0;
    src_init(3);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_m_tdata", m_axis_tdata, 0);
    chk("rst_m_tlast", {m_axis_tlast, m_axis_tuser, m_axis_tkeep}, 0);
    chk("rst_s_tready", s_axis_tready, 0);
    chk("rst_abort_count", abort_count, 0);
    reset = 1'b0;
    lim[0] = 4; lim[1] = 4; lnk = 1'b1; mon_on = 1;
    for (int t = 0; t < 200 && !(mp[0] == 4 && mp[1] == 4); t++) begin
      tick();
      if (m_hs) begin hc.push_back(cyc); hg.push_back(grant); end
    end
    chk("b_beats", hc.size(), 24);
    for (int k = 0; k < hc.size(); k++) begin
      if (k % 3 == 0) chk("b_rr_order", hg[k], (k / 3) % 2 ? 2 : 1);
      if (k > 0) chk("b_spacing", hc[k] - hc[k-1], k % 3 == 0 ? 2 : 1);
    end
    lnk = 1'b0; lim[0] = 5; bad = 0;
    repeat (50) begin
      tick();
      if (m_axis_tvalid !== 1'b0 || s_axis_tready !== '0) bad++;
    end
    chk("c_link_down_hold", bad, 0);
    lnk = 1'b1;
    tick();
    chk("c_arb_cycle", m_axis_tvalid, 0);
    tick();
    chk("c_first_valid", m_axis_tvalid, 1);
    chk("c_first_data", m_axis_tdata, dat(0, 4, 0));
    for (int t = 0; t < 20 && mp[0] != 5; t++) tick();
    lens[1][4] = 5; lim[1] = 5;
    for (int t = 0; t < 30 && !(own == 1 && mb[1] == 2); t++) tick();
    chk("d_mid_packet", mb[1], 2);
    lnk = 1'b0; lens[0][5] = 2; lim[0] = 6;
    for (int t = 0; t < 30 && mp[1] != 5; t++) tick();
    chk("d_finished", mp[1], 5);
    repeat (10) tick();
    chk("d_idle_grant", grant, 0);
    chk("d_idle_busy", busy, 0);
    mon_on = 0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    src_init(3);
    lens[1][0] = 5; lim[0] = 1; lim[1] = 1; budget[0] = 1; lnk = 1'b1;
    for (int t = 0; t < 10 && !m_hs; t++) tick();
    chk("e_first_beat", m_hs, 1);
    chk("e_grant", grant, 1);
    bad = 0;
    repeat (15) begin
      tick();
      if (m_axis_tvalid !== 1'b0) bad++;
    end
    chk("e_stall_quiet", bad, 0);
    tick();
    chk("e_abort_valid", m_axis_tvalid, 1);
    chk("e_abort_last", m_axis_tlast, 1);
    chk("e_abort_user", m_axis_tuser, 1);
    chk("e_abort_keep", m_axis_tkeep, 4'hF);
    chk("e_abort_data", m_axis_tdata, 0);
    tick();
    chk("e_abort_count", abort_count, 1);
    chk("e_drain_valid", m_axis_tvalid, 0);
    chk("e_drain_busy", busy, 1);
    chk("e_drain_tready", s_axis_tready, 3'b001);
    budget[0] = -1; drops = 0; seen = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (grant == 3'b010) break;
      drops += int'(hs[0]);
      seen += int'(m_axis_tvalid);
    end
    chk("e_next_grant", grant, 3'b010);
    chk("e_dropped_beats", drops, 2);
    chk("e_drain_no_output", seen, 0);
    chk("e_src1_first", m_axis_tdata, dat(1, 0, 0));
    mrdy = 0; bad = 0;
    repeat (5000) begin
      tick();
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== dat(1, 0, 1) || m_axis_tlast !== 1'b0 || grant !== 3'b010) bad++;
    end
    chk("f_stable", bad, 0);
    chk("f_no_abort", abort_count, 1);
    chk("f_busy", busy, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("r_grant", grant, 0);
    chk("r_busy", busy, 0);
    chk("r_s_tready", s_axis_tready, 0);
    chk("r_m_tvalid", m_axis_tvalid, 0);
    chk("r_abort_count", abort_count, 0);
    reset = 1'b0;
    src_init(0);
    for (int i = 0; i < N; i++) lim[i] = 20;
    gap = 30; mrdy = 70; lnk = 1'b1; mon_on = 1;
    for (int t = 0; t < 4000 && !(mp[0] == 20 && mp[1] == 20 && mp[2] == 20); t++) tick();
    for (int i = 0; i < N; i++) chk("g_packets", mp[i], 20);
    chk("g_abort_count", abort_count, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
